// File: rtl/snn_lif_layer.sv
// Leaky integrate-and-fire layer: leak, one pass over the weight memory, then fire.
// Optional refractory behaviour is compiled in with `define SNN_REFRACTORY_EN.

module snn_lif_neuron #(
    parameter int                    V_W        = 12,
    parameter logic signed [V_W-1:0] THRESH     = 64,
    parameter int                    LEAK_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              leak_en,
    input  logic              acc_en,
    input  logic              fire_en,
    input  logic signed [7:0] w,
    output logic              spike
);
    logic signed [V_W-1:0] v;
    logic signed [V_W:0]   sum;
    logic signed [V_W-1:0] v_sat;
    logic signed [V_W-1:0] v_leak;
    logic                  refr;
    logic                  fire_hit;

    assign sum    = {v[V_W-1], v} + {{(V_W-7){w[7]}}, w};
    assign v_leak = v - (v >>> LEAK_SHIFT);

    // Top two sum bits disagree only on overflow; clamp to the rail of the true sign.
    always_comb begin
        v_sat = sum[V_W-1:0];
        if (sum[V_W] != sum[V_W-1])
            v_sat = sum[V_W] ? {1'b1, {(V_W-1){1'b0}}} : {1'b0, {(V_W-1){1'b1}}};
    end

    assign fire_hit = !refr && (v >= THRESH);

`ifdef SNN_REFRACTORY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       refr <= 1'b0;
        else if (fire_en) refr <= fire_hit;
    end
`else
    assign refr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            spike <= 1'b0;
        end else if (fire_en) begin
            spike <= fire_hit;
            if (fire_hit || refr) v <= '0;
        end else if (leak_en && !refr) begin
            v <= v_leak;
        end else if (acc_en && !refr) begin
            v <= v_sat;
        end
    end
endmodule

module snn_lif_layer #(
    parameter int                    N_IN       = 4,
    parameter int                    N_OUT      = 2,
    parameter int                    V_W        = 12,
    parameter logic signed [V_W-1:0] THRESH     = 12'sd64,
    parameter int                    LEAK_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_IN-1:0]         in_spikes,
    output logic [3:0]              mem_addr,
    input  logic signed [7:0]       mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic [N_OUT-1:0]        out_spikes
);
    localparam int N_SYN = N_IN * N_OUT;

    typedef enum logic [2:0] {S_IDLE, S_LEAK, S_SCAN, S_DRAIN, S_FIRE} state_t;

    state_t          state;
    logic [3:0]      idx;
    logic [3:0]      idx_d;
    logic            acc_vld;
    logic [N_IN-1:0] spk_q;

    assign mem_addr = (state == S_SCAN) ? idx : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            spk_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    spk_q <= in_spikes;
                    busy  <= 1'b1;
                    state <= S_LEAK;
                end
                S_LEAK: begin
                    idx   <= '0;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    idx <= idx + 4'd1;
                    if (idx == 4'(N_SYN - 1)) begin
                        idx   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: state <= S_FIRE;
                S_FIRE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory data lags the address by one edge; idx_d names the weight now on mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_d   <= '0;
            acc_vld <= 1'b0;
        end else begin
            idx_d   <= idx;
            acc_vld <= (state == S_SCAN);
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        logic [N_IN-1:0] hit;
        for (genvar i = 0; i < N_IN; i++) begin : g_syn
            assign hit[i] = spk_q[i] && (idx_d == 4'(j * N_IN + i));
        end
        snn_lif_neuron #(
            .V_W       (V_W),
            .THRESH    (THRESH),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_neuron (
            .clk    (clk),
            .rst_n  (rst_n),
            .leak_en(state == S_LEAK),
            .acc_en (acc_vld && (|hit)),
            .fire_en(state == S_FIRE),
            .w      (mem_rdata),
            .spike  (out_spikes[j])
        );
    end
endmodule
